// File: rtl/stoch_square_root_nch.sv
// ============================================================================
// Module   : stoch_square_root_nch
// Brief    : NUM_CH-channel stochastic square root sharing one 64-bit LFSR.
// Revision : 1.0
// ============================================================================
`default_nettype none

module stoch_square_root_nch #(
    parameter int          NUM_CH       = 4,
    parameter int          CW           = 10,
    parameter int          STEP         = 4,
    parameter int          RAND_W       = 9,
    parameter int          LO_CLAMP     = -100,
    parameter int          HI_CLAMP     = 507,
    parameter int          DECORR_DEPTH = 4,
    parameter logic [63:0] SEED         = 64'hACE1_2468_BDF1_3579
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              en,
    input  logic              clr,
    input  logic [NUM_CH-1:0] a,
    output logic [NUM_CH-1:0] y,
    output logic [NUM_CH-1:0] sat_hi
);

    localparam logic signed [CW+1:0] STEP_S = (CW+2)'(STEP);
    localparam logic signed [CW+1:0] LO_S   = (CW+2)'(LO_CLAMP);
    localparam logic signed [CW+1:0] HI_S   = (CW+2)'(HI_CLAMP);

    logic [63:0] lfsr;
    logic        lfsr_fb;

    // Fibonacci taps 64,63,61,60 map to bit indices 63,62,60,59
    assign lfsr_fb = lfsr[63] ^ lfsr[62] ^ lfsr[60] ^ lfsr[59];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            lfsr <= SEED;
        end else if (en) begin
            lfsr <= {lfsr[62:0], lfsr_fb};
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic signed [CW-1:0]     cnt;
        logic                     b_and;
        logic [DECORR_DEPTH-1:0]  dly;
        logic                     sat;
        logic signed [CW+1:0]     cnt_x;
        logic signed [CW+1:0]     sum;
        logic signed [CW+1:0]     nxt_x;
        logic signed [CW-1:0]     nxt;
        logic signed [CW:0]       nxt_c;
        logic signed [CW:0]       r_c;
        logic                     y_c;
        logic                     dly_out;

        assign dly_out = dly[DECORR_DEPTH-1];

        always_comb begin
            cnt_x = {{2{cnt[CW-1]}}, cnt};
            sum   = cnt_x;
            if (a[i]) begin
                sum = sum + STEP_S;
            end
            if (b_and) begin
                sum = sum - STEP_S;
            end
            if (sum < LO_S) begin
                nxt_x = LO_S;
            end else if (sum > HI_S) begin
                nxt_x = HI_S;
            end else begin
                nxt_x = sum;
            end
            nxt   = nxt_x[CW-1:0];
            nxt_c = {nxt[CW-1], nxt};
            // Random word is always nonnegative, so zero-extend before the signed compare
            r_c   = {{(CW+1-RAND_W){1'b0}}, lfsr[i*RAND_W +: RAND_W]};
            y_c   = nRST & en & ~clr & (nxt_c > r_c);
        end

        always_ff @(posedge CLK or negedge nRST) begin
            if (!nRST) begin
                cnt   <= '0;
                b_and <= 1'b0;
                dly   <= '0;
                sat   <= 1'b0;
            end else if (clr) begin
                cnt   <= '0;
                b_and <= 1'b0;
                dly   <= '0;
                sat   <= 1'b0;
            end else if (en) begin
                cnt   <= nxt;
                dly   <= (dly << 1) | DECORR_DEPTH'(y_c);
                b_and <= y_c & dly_out;
                sat   <= sat | (sum >= HI_S);
            end
        end

        assign y[i]      = y_c;
        assign sat_hi[i] = sat;
    end : g_ch

endmodule

`default_nettype wire
